// File: rtl/gpio_evt_pkg.sv
// Shared types and helpers for the GPIO input event path.
package gpio_evt_pkg;

    typedef enum logic [1:0] {
        EVT_RISE  = 2'b00,
        EVT_FALL  = 2'b01,
        EVT_BOTH  = 2'b10,
        EVT_LEVEL = 2'b11
    } evt_type_e;

    localparam int FILT_W_DEF = 4;
    localparam int N_PIN_DEF  = 32;

    // Decide whether a pin raises an event this cycle.
    // upd: filter commits a new value at the coming edge, dir: that new value,
    // lvl: currently committed filtered value.
    function automatic logic evt_hit(input evt_type_e typ, input logic upd,
                                     input logic dir, input logic lvl);
        logic hit;
        case (typ)
            EVT_RISE:  hit = upd & dir;
            EVT_FALL:  hit = upd & ~dir;
            EVT_BOTH:  hit = upd;
            EVT_LEVEL: hit = lvl;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One pin: 2-flop synchroniser followed by a saturating glitch-filter counter.
// update_o/dir_o announce, one cycle ahead, that filt_o will take dir_o at the
// next edge, so the event logic can set status on that same edge.
module gpio_in_filter
    import gpio_evt_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pin_i,
    input  logic [FILT_W-1:0] thr_i,
    output logic              filt_o,
    output logic              update_o,
    output logic              dir_o
);

    logic              sync1_q;
    logic              sync2_q;
    logic              filt_q;
    logic              filt_d;
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;
    logic [FILT_W:0]   cnt_inc_s;
    logic              update_s;

    // Next-state logic of the filter: reset count on agreement, commit when threshold reached.
    always_comb begin
        cnt_inc_s = {1'b0, cnt_q} + {{FILT_W{1'b0}}, 1'b1};
        update_s  = (sync2_q != filt_q) && (cnt_inc_s >= {1'b0, thr_i});
        filt_d    = filt_q;
        cnt_d     = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = {FILT_W{1'b0}};
        end else if (update_s) begin
            filt_d = sync2_q;
            cnt_d  = {FILT_W{1'b0}};
        end else if (cnt_q == {FILT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_inc_s[FILT_W-1:0];
        end
    end

    // Synchroniser, counter and filtered value registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= {FILT_W{1'b0}};
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o   = filt_q;
    assign update_o = update_s;
    assign dir_o    = sync2_q;

endmodule

// File: rtl/gpio_in_event.sv
// Resynchronises and filters pad inputs, detects per-pin events into a sticky
// W1C status vector and raises an aggregated interrupt.
module gpio_in_event
    import gpio_evt_pkg::*;
#(
    parameter int N_PIN  = N_PIN_DEF,
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_PIN-1:0]   gpio_in_i,
    input  logic [N_PIN-1:0]   en_i,
    input  logic [2*N_PIN-1:0] type_i,
    input  logic [FILT_W-1:0]  filt_len_i,
    input  logic               clr_valid_i,
    input  logic [N_PIN-1:0]   clr_mask_i,
    output logic [N_PIN-1:0]   gpio_filt_o,
    output logic [N_PIN-1:0]   status_o,
    output logic               irq_o
);

    logic [FILT_W-1:0] thr_s;
    logic [N_PIN-1:0]  filt_s;
    logic [N_PIN-1:0]  upd_s;
    logic [N_PIN-1:0]  dir_s;
    logic [N_PIN-1:0]  event_s;
    logic [N_PIN-1:0]  status_q;
    logic [N_PIN-1:0]  status_d;

    // Threshold T = max(L,1): a zero length still needs one cycle of disagreement.
    always_comb begin
        if (filt_len_i == {FILT_W{1'b0}}) begin
            thr_s = {{(FILT_W-1){1'b0}}, 1'b1};
        end else begin
            thr_s = filt_len_i;
        end
    end

    for (genvar i = 0; i < N_PIN; i++) begin : g_pin
        gpio_in_filter #(
            .FILT_W (FILT_W)
        ) u_filter (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .pin_i    (gpio_in_i[i]),
            .thr_i    (thr_s),
            .filt_o   (filt_s[i]),
            .update_o (upd_s[i]),
            .dir_o    (dir_s[i])
        );

        assign event_s[i] = en_i[i] &
                            evt_hit(evt_type_e'(type_i[2*i +: 2]), upd_s[i], dir_s[i], filt_s[i]);
    end

    // Sticky status: clear requested bits, then OR in new events so a set always wins.
    always_comb begin
        status_d = status_q;
        if (clr_valid_i) begin
            status_d = status_q & ~clr_mask_i;
        end else begin
            status_d = status_q;
        end
        status_d = status_d | event_s;
    end

    // Status register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= {N_PIN{1'b0}};
        end else begin
            status_q <= status_d;
        end
    end

    assign gpio_filt_o = filt_s;
    assign status_o    = status_q;
    assign irq_o       = |status_q;

endmodule

// File: tb/tb_gpio_in_event.sv
// Directed bench for gpio_in_event: filter latency, glitch suppression,
// W1C set-wins, LEVEL events, enable gating and asynchronous reset.
module tb_gpio_in_event;

    logic        clk;
    logic        rst_n;
    logic [31:0] gpio_in;
    logic [31:0] en;
    logic [63:0] typ;
    logic [3:0]  filt_len;
    logic        clr_valid;
    logic [31:0] clr_mask;
    logic [31:0] gpio_filt;
    logic [31:0] status;
    logic        irq;

    int total = 0;
    int bad   = 0;

    gpio_in_event dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .gpio_in_i   (gpio_in),
        .en_i        (en),
        .type_i      (typ),
        .filt_len_i  (filt_len),
        .clr_valid_i (clr_valid),
        .clr_mask_i  (clr_mask),
        .gpio_filt_o (gpio_filt),
        .status_o    (status),
        .irq_o       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        gpio_in   = 32'h0;
        en        = 32'h0;
        typ       = 64'h0;
        filt_len  = 4'd3;
        clr_valid = 1'b0;
        clr_mask  = 32'h0;
        #2 rst_n = 1'b0;
        #10;
        chk("reset_filt", gpio_filt, 32'h0);
        chk("reset_status", status, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        edges(2);
        rst_n = 1'b1;
        edges(1);

        // 1: pin0 RISE, L=3 -> filtered high at edge 5
        en[0] = 1'b1; typ[1:0] = 2'b00; gpio_in[0] = 1'b1;
        edges(4);
        chk("t1_filt_edge4", {31'h0, gpio_filt[0]}, 32'h0);
        chk("t1_status_edge4", {31'h0, status[0]}, 32'h0);
        edges(1);
        chk("t1_filt_edge5", {31'h0, gpio_filt[0]}, 32'h1);
        chk("t1_status_edge5", status, 32'h1);
        chk("t1_irq", {31'h0, irq}, 32'h1);

        // 2: pin1 BOTH, 2-cycle glitch is suppressed
        en[1] = 1'b1; typ[3:2] = 2'b10; gpio_in[1] = 1'b1;
        edges(2);
        gpio_in[1] = 1'b0;
        edges(8);
        chk("t2_filt", {31'h0, gpio_filt[1]}, 32'h0);
        chk("t2_status", {31'h0, status[1]}, 32'h0);

        // 3: pin2 FALL, clear colliding with a new event
        en[2] = 1'b1; typ[5:4] = 2'b01; gpio_in[2] = 1'b1;
        edges(6);
        chk("t3_rise_no_fall_evt", {31'h0, status[2]}, 32'h0);
        gpio_in[2] = 1'b0;
        edges(6);
        chk("t3_first_fall", {31'h0, status[2]}, 32'h1);
        gpio_in[2] = 1'b1;
        edges(6);
        gpio_in[2] = 1'b0;
        edges(4);
        clr_valid = 1'b1; clr_mask = 32'h4;
        edges(1);
        clr_valid = 1'b0; clr_mask = 32'h0;
        chk("t3_set_wins_filt", {31'h0, gpio_filt[2]}, 32'h0);
        chk("t3_set_wins_status", {31'h0, status[2]}, 32'h1);
        clr_valid = 1'b1; clr_mask = 32'h5;
        edges(1);
        clr_valid = 1'b0; clr_mask = 32'h0;
        chk("t3_cleared_status", status, 32'h0);
        chk("t3_cleared_irq", {31'h0, irq}, 32'h0);

        // 4: pin3 LEVEL, clear pulsed every cycle
        en[3] = 1'b1; typ[7:6] = 2'b11; gpio_in[3] = 1'b1;
        edges(5);
        chk("t4_filt_high", {31'h0, gpio_filt[3]}, 32'h1);
        chk("t4_status_before", {31'h0, status[3]}, 32'h0);
        edges(1);
        chk("t4_status_set", {31'h0, status[3]}, 32'h1);
        clr_valid = 1'b1; clr_mask = 32'h8;
        edges(3);
        chk("t4_held_under_clear", {31'h0, status[3]}, 32'h1);
        gpio_in[3] = 1'b0;
        edges(5);
        chk("t4_filt_low", {31'h0, gpio_filt[3]}, 32'h0);
        chk("t4_last_level", {31'h0, status[3]}, 32'h1);
        edges(1);
        chk("t4_cleared", status, 32'h0);
        clr_valid = 1'b0; clr_mask = 32'h0;

        // 5: pin4 disabled, filtered value still follows
        typ[9:8] = 2'b10; gpio_in[4] = 1'b1;
        edges(5);
        chk("t5_filt_high", {31'h0, gpio_filt[4]}, 32'h1);
        chk("t5_no_status", {31'h0, status[4]}, 32'h0);
        gpio_in[4] = 1'b0;
        edges(5);
        chk("t5_filt_low", {31'h0, gpio_filt[4]}, 32'h0);
        en[4] = 1'b1;
        edges(3);
        chk("t5_enable_no_evt", status, 32'h0);

        // 6: async reset mid-count with L=5
        filt_len = 4'd5;
        en[6] = 1'b1; typ[13:12] = 2'b00; gpio_in[6] = 1'b1;
        edges(4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_filt", gpio_filt, 32'h0);
        chk("t6_async_status", status, 32'h0);
        chk("t6_async_irq", {31'h0, irq}, 32'h0);
        en = 32'h0;
        edges(1);
        rst_n = 1'b1;
        edges(6);
        chk("t6_filt_edge6", {31'h0, gpio_filt[6]}, 32'h0);
        edges(1);
        chk("t6_filt_edge7", gpio_filt, 32'h41);
        chk("t6_status", status, 32'h0);
        chk("t6_irq", {31'h0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
